// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_MAX_LSU_STREAK = 4;
    localparam int DEF_TIMEOUT        = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // Timeout counter width: at least 8 bits, wide enough to reach the limit.
    function automatic int cnt_width(input int limit);
        return (limit < 256) ? 8 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Response watchdog: counts WAIT cycles with no memory response, saturating at TIMEOUT.
// Latency: expire is combinational from the registered count in the cycle it reaches TIMEOUT.
// Backpressure: none; clr has priority over en.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] count;

    assign expire = en && (count == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one registered transaction at a time.
// Latency: grant cycle 0, mem_req_valid from cycle 1, response passes through combinationally in WAIT.
// Backpressure: req_ready only in IDLE for the single winner; mem_req_ready stalls in REQ.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MAX_LSU_STREAK = DEF_MAX_LSU_STREAK,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    bus_err
);

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    wen;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] wmask;
    } mem_req_t;

    arb_state_t    state_q, state_d;
    owner_t        owner_q;
    mem_req_t      req_q;
    logic [SW-1:0] lsu_streak;
    logic          bus_err_q;
    logic          contested, grant_ifu, grant_lsu;
    logic          resp_done;
    logic          to_clr, to_en, to_expire;

    assign contested = ifu_req_valid && lsu_req_valid;

    // LSU normally wins a contest; after MAX_LSU_STREAK contested wins the IFU is forced through.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == IDLE) begin
            if (contested) begin
                if (lsu_streak == SW'(MAX_LSU_STREAK)) grant_ifu = 1'b1;
                else                                   grant_lsu = 1'b1;
            end else if (ifu_req_valid) begin
                grant_ifu = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign to_clr = (state_q == REQ) && mem_req_ready;
    assign to_en  = (state_q == WAIT) && !mem_resp_valid;

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (to_clr),
        .en     (to_en),
        .expire (to_expire)
    );

    always_comb begin
        state_d   = state_q;
        resp_done = 1'b0;
        case (state_q)
            IDLE: if (grant_ifu || grant_lsu) state_d = REQ;
            REQ:  if (mem_req_ready) state_d = WAIT;
            WAIT: begin
                if (mem_resp_valid || to_expire) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IFU;
            req_q      <= '0;
            lsu_streak <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_ifu) begin
                owner_q    <= OWN_IFU;
                req_q      <= '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
                lsu_streak <= '0;
            end else if (grant_lsu) begin
                owner_q <= OWN_LSU;
                req_q   <= '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
                if (contested) lsu_streak <= lsu_streak + SW'(1);
            end
            if (to_expire) bus_err_q <= 1'b1;
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = req_q.addr;
    assign mem_wen       = req_q.wen;
    assign mem_wdata     = req_q.wdata;
    assign mem_wmask     = req_q.wmask;

    // A timeout abort returns zero data rather than whatever sits on mem_rdata.
    assign ifu_resp_valid = resp_done && (owner_q == OWN_IFU);
    assign lsu_resp_valid = resp_done && (owner_q == OWN_LSU);
    assign ifu_rdata      = (ifu_resp_valid && mem_resp_valid) ? mem_rdata : '0;
    assign lsu_rdata      = (lsu_resp_valid && mem_resp_valid) ? mem_rdata : '0;

    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an expected-transaction scoreboard.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_LSU_STREAK(4), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    typedef struct {
        logic        own;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_streak = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_addr"}, {32'h0, mem_addr}, {32'h0, sb[0].addr});
        chk({tag, "_wfields"}, {27'h0, mem_wen, mem_wmask, mem_wdata},
            {27'h0, sb[0].wen, sb[0].wmask, sb[0].wdata});
    endtask

    // Starts and ends at posedge+1 with the DUT idle.
    task automatic do_txn(input logic lsu, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
        exp_t e;
        e.own   = lsu;
        e.addr  = addr;
        e.wen   = lsu ? wen : 1'b0;
        e.wdata = lsu ? wdata : 32'h0;
        e.wmask = lsu ? wmask : 4'h0;
        e.rdata = rdata;
        sb.push_back(e);
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen;
            lsu_wdata = wdata; lsu_wmask = wmask;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
            m_streak = 0;
        end
        @(negedge clk);
        chk("grant", {62'h0, ifu_req_ready, lsu_req_ready}, lsu ? 64'h1 : 64'h2);
        step();
        for (int i = 0; i < rdy_dly; i++) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            ifu_addr = ~addr; lsu_addr = ~addr; lsu_wdata = ~wdata;
            @(negedge clk);
            chk("stall_req_valid", {63'h0, mem_req_valid}, 64'h1);
            chk("stall_no_ready", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
            chk_fields("stall");
            step();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", {63'h0, mem_req_valid}, 64'h1);
        chk_fields("req");
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            chk("wait_no_resp", {62'h0, ifu_resp_valid, lsu_resp_valid}, 64'h0);
            chk_fields("wait");
            step();
        end
        mem_resp_valid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        e = sb.pop_front();
        chk("resp_owner", {62'h0, ifu_resp_valid, lsu_resp_valid}, e.own ? 64'h1 : 64'h2);
        if (!e.wen) chk("resp_rdata", {32'h0, e.own ? lsu_rdata : ifu_rdata}, {32'h0, e.rdata});
        step();
        @(negedge clk);
        chk("idle_resp_ignored", {61'h0, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 64'h0);
        step();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        logic own;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
        chk("rst_mem_req", {58'h0, mem_req_valid, mem_wen, mem_wmask}, 64'h0);
        chk("rst_mem_data", {mem_addr, mem_wdata}, 64'h0);
        chk("rst_resp", {ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata[29:0]}, 64'h0);
        chk("rst_bus_err", {63'h0, bus_err}, 64'h0);
        chk("rst_state", {62'h0, dut.state_q}, {62'h0, IDLE});
        @(posedge clk); #1;
        rst = 1'b1;

        // Single fetch, store, backpressured load
        do_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0010_0093, 0, 0);
        do_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h1, 32'h0, 0, 1);
        do_txn(1'b1, 32'h8000_2000, 1'b0, 32'h1111_2222, 4'hF, 32'hCAFE_F00D, 5, 2);

        // Contention: both valid every cycle, memory zero-wait
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h5A5A_0000;
        for (int g = 0; g < 10; g++) begin
            if (m_streak == 4) begin own = 1'b0; m_streak = 0; end
            else begin own = 1'b1; m_streak++; end
            e.own = own; e.addr = own ? 32'h0000_2000 : 32'h0000_1000;
            e.wen = 1'b0; e.wdata = 32'h0; e.wmask = 4'h0; e.rdata = 32'h5A5A_0000;
            sb.push_back(e);
            @(negedge clk);
            chk("cont_grant", {62'h0, ifu_req_ready, lsu_req_ready}, own ? 64'h1 : 64'h2);
            step();
            @(negedge clk);
            chk("cont_req_addr", {32'h0, mem_addr}, {32'h0, sb[0].addr});
            chk("cont_req_no_resp", {62'h0, ifu_resp_valid, lsu_resp_valid}, 64'h0);
            step();
            @(negedge clk);
            e = sb.pop_front();
            chk("cont_resp_owner", {62'h0, ifu_resp_valid, lsu_resp_valid}, e.own ? 64'h1 : 64'h2);
            step();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

        // Timeout: memory never answers
        e.own = 1'b0; e.addr = 32'h8000_0040; e.wen = 1'b0;
        e.wdata = 32'h0; e.wmask = 4'h0; e.rdata = 32'h0;
        sb.push_back(e);
        m_streak = 0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        @(negedge clk);
        chk("to_grant", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h2);
        step();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid) break;
            n++;
            step();
        end
        chk("to_wait_cycles", 64'(n), 64'd255);
        e = sb.pop_front();
        chk("to_resp_owner", {62'h0, ifu_resp_valid, lsu_resp_valid}, 64'h2);
        chk("to_rdata_zero", {32'h0, ifu_rdata}, {32'h0, e.rdata});
        chk("to_bus_err_pre", {63'h0, bus_err}, 64'h0);
        step();
        @(negedge clk);
        chk("to_bus_err_set", {63'h0, bus_err}, 64'h1);
        step();
        do_txn(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 0, 0);
        @(negedge clk);
        chk("to_bus_err_sticky", {63'h0, bus_err}, 64'h1);
        step();

        // Reset asserted mid-WAIT
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0;
        @(negedge clk);
        chk("mr_grant", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h1);
        step();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hABCD_0123;
        #1;
        chk("mr_outputs", {58'h0, ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                           lsu_resp_valid, mem_req_valid, bus_err}, 64'h0);
        chk("mr_mem_addr", {32'h0, mem_addr}, 64'h0);
        chk("mr_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
        chk("mr_state", {62'h0, dut.state_q}, {62'h0, IDLE});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_streak = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_no_pulse", {61'h0, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 64'h0);
            step();
        end
        mem_resp_valid = 1'b0;
        do_txn(1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
